// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the state encoding, width defaults and the HALT opcode.
package fetch_pkg;

  localparam int unsigned PW_DEF = 8;
  localparam int unsigned IW_DEF = 9;
  localparam int unsigned CYC_W  = 16;

  localparam logic [8:0] HALT_DEF = 9'b0_111_11111;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Core-side responder of the Start/Ack run handshake: fetches from the instruction ROM,
// issues to decode, and reports completion on HALT retire or cycle-budget exhaustion.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    PW         = PW_DEF,
  parameter int unsigned    IW         = IW_DEF,
  parameter logic [PW-1:0]  START_PC   = '0,
  parameter logic [IW-1:0]  HALT_INSTR = IW'(HALT_DEF),
  parameter int unsigned    MAX_CYCLES = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic [PW-1:0]    RomAddr,
  input  logic [IW-1:0]    RomData,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [PW-1:0]    BranchTarget,
  output logic [IW-1:0]    Instruction,
  output logic             InstrValid,
  output logic             Ack,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCount
);

  localparam logic [CYC_W-1:0] BudgetLast = CYC_W'(MAX_CYCLES - 1);

  fetch_state_t     state_q, state_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic             halt_retire;
  logic             budget_out;
  logic [CYC_W-1:0] cyc_inc;

  assign halt_retire = valid_q && !Stall && (instr_q == HALT_INSTR);
  assign budget_out  = (cyc_q == BudgetLast);
  assign cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    cyc_d     = cyc_q;

    unique case (state_q)
      IDLE: begin
        if (Start) state_d = ARMED;
      end
      ARMED: begin
        if (!Start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          cyc_d     = '0;
          timeout_d = 1'b0;
          valid_d   = 1'b0;
        end
      end
      RUN: begin
        // Cycles are counted even while stalled; only fetch/retire freeze.
        cyc_d = cyc_inc;
        if (halt_retire || budget_out) begin
          state_d   = DONE;
          ack_d     = 1'b1;
          timeout_d = !halt_retire;
          valid_d   = 1'b0;
        end else if (!Stall) begin
          if (valid_q && BranchTaken) begin
            // Squash the in-flight fetch; target is fetched next cycle.
            pc_d    = BranchTarget;
            valid_d = 1'b0;
          end else begin
            instr_d = RomData;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = ARMED;
          ack_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
    end
  end

  assign RomAddr     = pc_q;
  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign Ack         = ack_q;
  assign Timeout     = timeout_q;
  assign CycleCount  = cyc_q;

endmodule
